// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
// Contents: default bus widths, FSM state codes, request-kind enum and decoder.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 32;

  // FSM state codes kept as plain constants so the state register is a simple vector.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    KIND_NULL  = 2'd0,
    KIND_READ  = 2'd1,
    KIND_WRITE = 2'd2
  } kind_e;

  // A nonzero byte mask always wins: a request with both rd and a mask is a write.
  function automatic kind_e decode_kind(input logic mask_nz, input logic rd);
    if (mask_nz) begin
      return KIND_WRITE;
    end else if (rd) begin
      return KIND_READ;
    end
    return KIND_NULL;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses which requesting port is granted.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: valid[1:0] requests in, last_grant (port served last) in,
//        grant (index of chosen port) out, any (some request present) out.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |valid;
    // On a tie the port that was not served last wins; otherwise the lone requester.
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one word-wide SDRAM controller between instruction port 0 and data port 1.
// Latency: accept t, command at t+1 (if controller idle), response t+3+B for B busy cycles; null t+1.
// Backpressure: one request in flight; no acceptance until the response handshake completes.
// Ports: CLK/RST (sync, active-high); pN_req_* request channel with req_ready;
//        pN_rsp_* valid/ready response channel; sd_* controller command/busy interface.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_W-1:0]     p0_req_addr,
  input  logic [DATA_W-1:0]     p0_req_wdata,
  input  logic [DATA_W/8-1:0]   p0_req_wmask,
  input  logic                  p0_req_rd,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_W-1:0]     p0_rsp_data,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_W-1:0]     p1_req_addr,
  input  logic [DATA_W-1:0]     p1_req_wdata,
  input  logic [DATA_W/8-1:0]   p1_req_wmask,
  input  logic                  p1_req_rd,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_W-1:0]     p1_rsp_data,

  output logic [ADDR_W-1:0]     sd_addr,
  output logic [DATA_W-1:0]     sd_din,
  output logic [DATA_W/8-1:0]   sd_wmask,
  output logic                  sd_rd,
  input  logic [DATA_W-1:0]     sd_dout,
  input  logic                  sd_busy
);

  localparam int MASK_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              seen_busy_q, seen_busy_d;
  logic              owner_q, owner_d;
  kind_e             kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              grant;
  logic              any;
  logic              accept;
  logic              owner_rsp_ready;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_wmask;
  logic              sel_rd;
  kind_e             sel_kind;

  rr_pick2 u_pick (
    .valid      ({p1_req_valid, p0_req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any        (any)
  );

  always_comb begin
    sel_addr  = grant ? p1_req_addr  : p0_req_addr;
    sel_wdata = grant ? p1_req_wdata : p0_req_wdata;
    sel_wmask = grant ? p1_req_wmask : p0_req_wmask;
    sel_rd    = grant ? p1_req_rd    : p0_req_rd;
    sel_kind  = decode_kind(|sel_wmask, sel_rd);
    owner_rsp_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    owner_d      = owner_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rsp_data_d   = rsp_data_q;
    // Ready is suppressed during reset so nothing is handed over in a cycle that gets discarded.
    accept       = (state_q == ST_IDLE) && any && !RST;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wmask_d = sel_wmask;
          kind_d  = sel_kind;
          if (sel_kind == KIND_NULL) begin
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // The controller samples the command on any cycle it is not busy,
        // including a busy left over from before a reset.
        if (!sd_busy) begin
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion is the falling edge of busy, so busy must be seen high first.
        if (sd_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          rsp_data_d = (kind_q == KIND_READ) ? sd_dout : '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      seen_busy_q  <= 1'b0;
      owner_q      <= 1'b0;
      kind_q       <= KIND_NULL;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      seen_busy_q  <= seen_busy_d;
      owner_q      <= owner_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign p0_req_ready = accept && !grant;
  assign p1_req_ready = accept && grant;

  assign p0_rsp_valid = (state_q == ST_RESP) && !owner_q;
  assign p1_rsp_valid = (state_q == ST_RESP) && owner_q;
  assign p0_rsp_data  = rsp_data_q;
  assign p1_rsp_data  = rsp_data_q;

  // Address and data simply follow the latch; only the strobes are limited to ISSUE.
  assign sd_addr  = addr_q;
  assign sd_din   = wdata_q;
  assign sd_rd    = (state_q == ST_ISSUE) && (kind_q == KIND_READ);
  assign sd_wmask = ((state_q == ST_ISSUE) && (kind_q == KIND_WRITE)) ? wmask_q : '0;

endmodule
